// File: rtl/sixteen_bit_seq_multiplier_if.sv
// Operand/result bus for the sequential 16x16 multiplier.
interface sixteen_bit_seq_multiplier_if;
    logic        start;
    logic        signed_op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    modport master (
        output start, signed_op, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_op, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/sixteen_bit_seq_multiplier.sv
// Sequential shift-add 16x16 multiplier (signed or unsigned) built around a
// single 16-bit ripple adder; one iteration per clock, 16 iterations per op.

// 16-bit ripple-carry adder with carry out and signed overflow flag.
module sixteen_bit_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out,
    output logic        overflow
);
    logic [16:0] carry;

    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bit
            assign sum[gi]        = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out    = carry[16];
    assign overflow = carry[16] ^ carry[15];
endmodule

module sixteen_bit_seq_multiplier (
    input  logic                               clk,
    input  logic                               reset,
    sixteen_bit_seq_multiplier_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  count_reg;
    logic [31:0] acc_reg;
    logic [15:0] mcand_reg;
    logic [15:0] mplier_reg;
    logic        neg_reg;
    logic [31:0] product_reg;

    logic [15:0] add_sum;
    logic        add_c_out;
    logic [31:0] acc_shift;
    logic [31:0] result;
    logic [15:0] a_mag;
    logic [15:0] b_mag;

    // Operand magnitudes; 0x8000 negates to itself, which is the correct
    // unsigned magnitude of -32768.
    assign a_mag = (bus.signed_op & bus.a[15]) ? (~bus.a + 16'd1) : bus.a;
    assign b_mag = (bus.signed_op & bus.b[15]) ? (~bus.b + 16'd1) : bus.b;

    // Upper accumulator half plus multiplicand; carry becomes bit 32.
    sixteen_bit_adder u_adder (
        .a        (acc_reg[31:16]),
        .b        (mcand_reg),
        .c_in     (1'b0),
        .sum      (add_sum),
        .c_out    (add_c_out),
        .overflow ()
    );

    // Accumulator after this edge's add-and-shift.
    assign acc_shift = mplier_reg[0] ? {add_c_out, add_sum, acc_reg[15:1]}
                                     : {1'b0, acc_reg[31:1]};
    assign result    = neg_reg ? (~acc_shift + 32'd1) : acc_shift;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: DONE always lasts a single cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (count_reg == 4'd15) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture in IDLE, one shift-add per RUN cycle,
    // product load on the final iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg   <= 4'd0;
            acc_reg     <= 32'd0;
            mcand_reg   <= 16'd0;
            mplier_reg  <= 16'd0;
            neg_reg     <= 1'b0;
            product_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        count_reg  <= 4'd0;
                        acc_reg    <= 32'd0;
                        mcand_reg  <= a_mag;
                        mplier_reg <= b_mag;
                        neg_reg    <= bus.signed_op & (bus.a[15] ^ bus.b[15]);
                    end
                end
                RUN: begin
                    acc_reg    <= acc_shift;
                    mplier_reg <= {1'b0, mplier_reg[15:1]};
                    count_reg  <= count_reg + 4'd1;
                    if (count_reg == 4'd15) begin
                        product_reg <= result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = (state_reg == DONE);
    assign bus.product = product_reg;
endmodule

// File: doc/sixteen_bit_seq_multiplier.md
SIXTEEN_BIT_SEQ_MULTIPLIER -- requirements
Module: sixteen_bit_seq_multiplier

Interface
REQ-001 Parameters: none; operand width is fixed at 16 bits to match sixteen_bit_adder.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 signed_op  input  1  1 = two's-complement operands, 0 = unsigned; captured with operands.
REQ-006 a  input  16  multiplicand; captured on the accepting edge.
REQ-007 b  input  16  multiplier; captured on the accepting edge.
REQ-008 busy  output  1  high while state is RUN or DONE.
REQ-009 done  output  1  one-cycle pulse; product is valid while high.
REQ-010 product  output  32  registered result; held until the next accepted start.

Function
REQ-011 The block SHALL contain a state machine with states IDLE, RUN, DONE; busy = (state != IDLE), done = (state == DONE).
REQ-012 IDLE: start=1 at an edge SHALL capture operands, set iteration count=0, clear the accumulator, and go to RUN; start=0 stays in IDLE.
REQ-013 Capture SHALL store magnitudes: if signed_op=1 and an operand bit15=1, its two's-complement negation (0x8000 stays 0x8000 as unsigned magnitude); neg_result = signed_op & (a[15] ^ b[15]).
REQ-014 RUN SHALL perform exactly one shift-add iteration per edge: if multiplier LSB=1, upper accumulator half = sum of upper half and multiplicand magnitude, with C_out as the new bit 32; then shift accumulator and multiplier right by one.
REQ-015 Accumulation SHALL use one instance of sixteen_bit_adder (C_in tied 0); C_out supplies the carry, overflow is unused.
REQ-016 After the 16th RUN iteration (count reaches 15 on that edge), the same edge SHALL load product with the accumulator, two's-complement negated over 32 bits if neg_result=1, and go to DONE.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge N, done=1 between edges N+16 and N+17; busy=1 from edge N through edge N+17.
REQ-019 start SHALL be ignored in RUN and DONE; operand changes during busy SHALL not affect the result.
REQ-020 A new start is accepted no earlier than the first edge in IDLE (edge N+18 at the earliest when start is held high); no back-to-back issue from DONE.
REQ-021 product SHALL change only on the DONE-entry edge or on reset; it retains its value through IDLE and the next RUN.
REQ-022 Zero operands SHALL still take the full 16-iteration latency (no early termination).
REQ-023 Results: unsigned mode gives a 32-bit unsigned product; signed mode gives a 32-bit two's-complement product. Neither mode overflows.

Reset
REQ-024 reset=1 at an edge SHALL force state=IDLE, count=0, accumulator=0, product=0x00000000, busy=0, done=0.
REQ-025 reset takes priority over start and over any in-progress iteration; a multiply aborted mid-RUN SHALL produce no done pulse.
REQ-026 The first start after reset release SHALL be accepted normally at the next edge.

Verification
REQ-027 unsigned a=0xFFFF, b=0xFFFF, start at edge N -> done=1 only between N+16 and N+17, product=0xFFFE0001.
REQ-028 signed_op=1, a=0xFFFF (-1), b=0x0003 -> product=0xFFFFFFFD; a=0x8000, b=0x8000 -> product=0x40000000.
REQ-029 signed_op=1, a=0x7FFF, b=0x8000 -> product=0xC0008000; signed_op=0, same operands -> product=0x3FFF8000.
REQ-030 start held high with a and b changed every cycle while busy -> exactly one done per 18 cycles; each product matches operands captured at the accepting edge.
REQ-031 reset pulsed at the 8th RUN iteration -> next cycle busy=0, done=0, product=0x00000000, no done pulse; next start a=0x0002, b=0x0003 -> product=0x00000006.
REQ-032 a=0x0000, b=0x1234 -> product=0x00000000 with full 16-cycle latency; previous product held until the DONE-entry edge.
